// File: rtl/comp_pio_pkg.sv
// Shared definitions for the PIO family: register word addresses and edge-capture encodings.
package comp_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

endpackage

// File: rtl/comp_pio_sync_edge.sv
// Input synchronizer, one-cycle delay and edge detector for the input PIO.
// Detection stays masked after reset until the chain holds real samples.
module comp_pio_sync_edge
  import comp_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] data_q,
  output logic [DATA_WIDTH-1:0] det
);

  localparam int ARM_CNT = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_CNT + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q, sync_d;
  logic [DATA_WIDTH-1:0]                  prev_q, prev_d;
  logic [ARM_W-1:0]                       arm_q, arm_d;
  logic                                   armed;
  logic [DATA_WIDTH-1:0]                  rise, fall, sel;

  assign data_q = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_q == ARM_W'(ARM_CNT));

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d = data_q;
    arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  always_comb begin
    rise = data_q & ~prev_q;
    fall = ~data_q & prev_q;
    case (EDGE_TYPE)
      int'(EDGE_FALLING): sel = fall;
      int'(EDGE_ANY):     sel = rise | fall;
      default:            sel = rise;
    endcase
    det = armed ? sel : '0;
  end

endmodule

// File: rtl/comp_data_in_pio.sv
// Avalon-MM input PIO: synchronized data register, irq mask and sticky W1C edge capture.
module comp_data_in_pio
  import comp_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] det;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [DATA_WIDTH-1:0] clr;
  logic                  wr_en;

  comp_pio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .data_q (data_q),
    .det    (det)
  );

  assign wr_en = chipselect & ~write_n;

  // Detect is OR-ed after the clear so a same-cycle edge survives the write.
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (wr_en && address == ADDR_IRQMASK) irq_mask_d = writedata[DATA_WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) clr = writedata[DATA_WIDTH-1:0];
    edge_cap_d = (edge_cap_q & ~clr) | det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(data_q);
      ADDR_DIR:     readdata = '0;
      ADDR_IRQMASK: readdata = 32'(irq_mask_q);
      ADDR_EDGECAP: readdata = 32'(edge_cap_q);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_comp_data_in_pio.sv
// Scoreboard bench for comp_data_in_pio: a rising-edge instance and an any-edge instance.
module tb_comp_data_in_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port0, in_port2;
  logic [31:0] readdata0, readdata2;
  logic        irq0, irq2;

  typedef struct {
    int          dut;
    bit          is_irq;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  bit   chk_req;
  int   total;
  int   bad;

  comp_data_in_pio #(.DATA_WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port0),
    .readdata(readdata0), .irq(irq0)
  );

  comp_data_in_pio #(.DATA_WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation whenever a check is presented on the bus.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (chk_req) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: check presented with no expectation queued");
        end else begin
          e = sb.pop_front();
          if (e.is_irq) act = {31'd0, (e.dut == 0) ? irq0 : irq2};
          else          act = (e.dut == 0) ? readdata0 : readdata2;
          if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input int d, input bit is_irq, input logic [1:0] a,
                     input logic [31:0] exp, input string nm);
    exp_t e;
    e.dut    = d;
    e.is_irq = is_irq;
    e.exp    = exp;
    e.name   = nm;
    sb.push_back(e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    chk_req    = 1'b1;
    tick(1);
    chk_req    = 1'b0;
    chipselect = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    chk_req    = 1'b0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port0   = 32'hFFFF_FFFF;
    in_port2   = 32'd0;

    // Reset with input held high
    tick(2);
    chk(0, 1, 2'd0, 32'd0, "irq_in_reset");
    chk(0, 0, 2'd3, 32'd0, "cap_in_reset");
    reset_n = 1'b1;
    chk(0, 0, 2'd0, 32'd0,          "data_0_edges");
    chk(0, 0, 2'd0, 32'd0,          "data_1_edge");
    chk(0, 0, 2'd0, 32'hFFFF_FFFF,  "data_2_edges");
    chk(0, 0, 2'd3, 32'd0,          "no_spurious_cap");
    chk(0, 0, 2'd1, 32'd0,          "dir_reads_zero");
    chk(0, 1, 2'd0, 32'd0,          "irq_after_reset");

    // Rising capture 0 -> 5
    in_port0 = 32'd0;
    tick(4);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port0 = 32'h0000_0005;
    chk(0, 0, 2'd3, 32'd0, "cap_before_e1");
    chk(0, 0, 2'd0, 32'd0, "data_before_e2");
    chk(0, 0, 2'd3, 32'd0, "cap_before_e3");
    chk(0, 0, 2'd3, 32'h5, "cap_after_e3");
    wr(2'd2, 32'h4);
    chk(0, 0, 2'd2, 32'h4, "mask_readback");
    chk(0, 1, 2'd0, 32'd1, "irq_mask4");
    wr(2'd2, 32'h0);
    chk(0, 1, 2'd0, 32'd0, "irq_mask0");

    // Write-1-to-clear
    wr(2'd2, 32'h4);
    wr(2'd3, 32'h1);
    chk(0, 0, 2'd3, 32'h4, "w1c_bit0");
    chk(0, 1, 2'd0, 32'd1, "irq_still_set");
    wr(2'd3, 32'h4);
    chk(0, 0, 2'd3, 32'h0, "w1c_bit2");
    chk(0, 1, 2'd0, 32'd0, "irq_after_clear");

    // Same-cycle detect and clear on bit 0
    in_port0 = 32'h4;
    tick(4);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port0 = 32'h5;
    tick(2);
    wr(2'd3, 32'h1);
    chk(0, 0, 2'd3, 32'h1, "set_wins_clear");
    wr(2'd3, 32'h1);
    chk(0, 0, 2'd3, 32'h0, "clear_after_set");

    // Reset mid-operation
    in_port0 = 32'hF5;
    tick(4);
    wr(2'd2, 32'hFF);
    chk(0, 0, 2'd3, 32'hF0, "cap_f0");
    chk(0, 1, 2'd0, 32'd1,  "irq_before_reset");
    reset_n = 1'b0;
    chk(0, 1, 2'd0, 32'd0,  "irq_async_reset");
    reset_n = 1'b1;
    chk(0, 0, 2'd2, 32'd0,  "mask_after_reset");
    chk(0, 0, 2'd3, 32'd0,  "cap_after_reset");
    tick(3);
    chk(0, 0, 2'd3, 32'd0,  "cap_rearm_static");

    // Any-edge instance: pulse bit 31
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0);
    in_port2 = 32'h8000_0000;
    tick(3);
    chk(2, 0, 2'd3, 32'h8000_0000, "any_rise_cap");
    tick(1);
    in_port2 = 32'd0;
    wr(2'd3, 32'h8000_0000);
    chk(2, 0, 2'd3, 32'd0,          "any_cleared");
    chk(2, 0, 2'd3, 32'd0,          "any_before_fall");
    chk(2, 0, 2'd3, 32'h8000_0000, "any_fall_cap");

    tick(1);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: %0d expectations not consumed", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
